// File: rtl/pattern_scan_engine_pkg.sv
// pattern_scan_pkg: shared types and helpers for pattern_scan_engine.
// Holds the scan FSM state encoding, the window-match helper and a popcount.
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bit k of the result is set when the pat_w-bit window vec[k+pat_w-1:k]
    // matches pat under mask. vec holds {carry, byte} right-aligned, so bit k
    // is the window whose last (least significant) bit is byte bit k.
    function automatic logic [7:0] window_hits(input logic [14:0] vec,
                                               input logic [7:0]  pat,
                                               input logic [7:0]  mask,
                                               input int unsigned pat_w);
        logic [7:0] width_mask;
        logic [7:0] win;
        logic [7:0] hits;
        width_mask = 8'((16'd1 << pat_w) - 16'd1);
        hits       = 8'd0;
        for (int k = 0; k < 8; k++) begin
            win     = vec[k +: 8] & width_mask;
            hits[k] = (((win ^ pat) & mask & width_mask) == 8'd0);
        end
        return hits;
    endfunction

    // Number of set bits in an 8-bit vector.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pattern_scan_engine_if.sv
// pattern_scan_engine_if: data-memory read port (strobe, address, data).
// Read data is returned exactly one cycle after the strobe.
interface pattern_scan_engine_if #(
    parameter int ADDR_W = 8
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;

    modport master (output mem_rd, output mem_addr, input mem_rdata);
    modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/pattern_scan_engine_window_matcher.sv
// window_matcher: combinational match of all windows ending in one byte.
// Bits k = 0..8-PAT_W of the byte are in-byte windows; the rest cross into
// the carry from the previous byte and are suppressed for the first byte.
module window_matcher
    import pattern_scan_pkg::*;
#(
    parameter int PAT_W = 5
) (
    input  logic [PAT_W+6:0] window_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [PAT_W-1:0] mask_i,
    input  logic             first_i,
    output logic [3:0]       stream_cnt_o,
    output logic [3:0]       inbyte_cnt_o,
    output logic             any_inbyte_o
);
    localparam logic [7:0] INBYTE_SEL = 8'((16'd1 << (9 - PAT_W)) - 16'd1);

    logic [7:0] hits_s;
    logic [7:0] inbyte_s;
    logic [7:0] stream_s;

    // Evaluate the eight windows and split them into in-byte / stream sets.
    always_comb begin
        hits_s   = window_hits(15'(window_i), 8'(pattern_i), 8'(mask_i), PAT_W);
        inbyte_s = hits_s & INBYTE_SEL;
        if (first_i) begin
            stream_s = inbyte_s;
        end else begin
            stream_s = hits_s;
        end
        stream_cnt_o = popcount8(stream_s);
        inbyte_cnt_o = popcount8(inbyte_s);
        any_inbyte_o = |inbyte_s;
    end
endmodule

// File: rtl/pattern_scan_engine.sv
// pattern_scan_engine: streams NBYTES bytes from data memory and counts
// PAT_W-bit pattern matches (in-byte, bytes with a hit, whole bit stream).
// Optional feature macro: PATCNT_MASK_EN adds a pat_mask input port that
// selects which pattern bits take part in the compare.
module pattern_scan_engine
    import pattern_scan_pkg::*;
#(
    parameter int PAT_W  = 5,
    parameter int NBYTES = 32,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = $clog2(8 * NBYTES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [PAT_W-1:0]      pattern,
`ifdef PATCNT_MASK_EN
    input  logic [PAT_W-1:0]      pat_mask,
`endif
    input  logic [ADDR_W-1:0]     base_addr,
    pattern_scan_engine_if.master mem,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      cnt_inbyte,
    output logic [CNT_W-1:0]      cnt_bytes,
    output logic [CNT_W-1:0]      cnt_stream
);
    localparam logic [7:0] LAST_IDX = 8'(NBYTES - 1);

    state_e            state_q, state_d;
    logic              start_acc_s;
    logic              busy_d, done_d, rd_d;
    logic              busy_q, done_q, rd_q, valid_q, first_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        idx_q;
    logic [PAT_W-1:0]  pattern_q;
    logic [PAT_W-1:0]  mask_s;
    logic [PAT_W-2:0]  carry_q;
    logic [CNT_W-1:0]  cnt_inbyte_q, cnt_bytes_q, cnt_stream_q;
    logic [3:0]        stream_cnt_s, inbyte_cnt_s;
    logic              any_inbyte_s;

`ifdef PATCNT_MASK_EN
    logic [PAT_W-1:0]  mask_q;
    assign mask_s = mask_q;
`else
    assign mask_s = {PAT_W{1'b1}};
`endif

    // A start is honoured only when no run is in flight.
    assign start_acc_s = start && ((state_q == IDLE) || (state_q == DONE));

    window_matcher #(.PAT_W(PAT_W)) u_matcher (
        .window_i     ({carry_q, mem.mem_rdata}),
        .pattern_i    (pattern_q),
        .mask_i       (mask_s),
        .first_i      (first_q),
        .stream_cnt_o (stream_cnt_s),
        .inbyte_cnt_o (inbyte_cnt_s),
        .any_inbyte_o (any_inbyte_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH; else state_d = IDLE;
            FETCH:   if (idx_q == LAST_IDX) state_d = DRAIN; else state_d = FETCH;
            DRAIN:   state_d = DONE;
            DONE:    if (start) state_d = FETCH; else state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, computed from the next state so they register in step with it.
    always_comb begin
        busy_d = (state_d == FETCH) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        rd_d   = (state_d == FETCH);
    end

    // Address counter, pattern latch, carry register and accumulators.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_q         <= 1'b0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            addr_q       <= '0;
            idx_q        <= 8'd0;
            pattern_q    <= '0;
`ifdef PATCNT_MASK_EN
            mask_q       <= '0;
`endif
            carry_q      <= '0;
            cnt_inbyte_q <= '0;
            cnt_bytes_q  <= '0;
            cnt_stream_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            valid_q <= rd_q;
            if (start_acc_s) begin
                pattern_q    <= pattern;
`ifdef PATCNT_MASK_EN
                mask_q       <= pat_mask;
`endif
                addr_q       <= base_addr;
                idx_q        <= 8'd0;
                first_q      <= 1'b1;
                carry_q      <= '0;
                cnt_inbyte_q <= '0;
                cnt_bytes_q  <= '0;
                cnt_stream_q <= '0;
            end else begin
                if ((state_q == FETCH) && (state_d == FETCH)) begin
                    addr_q <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    idx_q  <= idx_q + 8'd1;
                end
                if (valid_q) begin
                    cnt_stream_q <= cnt_stream_q + CNT_W'(stream_cnt_s);
                    cnt_inbyte_q <= cnt_inbyte_q + CNT_W'(inbyte_cnt_s);
                    cnt_bytes_q  <= cnt_bytes_q + CNT_W'(any_inbyte_s);
                    carry_q      <= mem.mem_rdata[PAT_W-2:0];
                    first_q      <= 1'b0;
                end
            end
        end
    end

    assign mem.mem_rd   = rd_q;
    assign mem.mem_addr = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cnt_inbyte   = cnt_inbyte_q;
    assign cnt_bytes    = cnt_bytes_q;
    assign cnt_stream   = cnt_stream_q;
endmodule

// File: tb/tb_pattern_scan_engine.sv
// tb_pattern_scan_engine: directed tests for pattern_scan_engine.
// Instance A uses the default geometry (PAT_W=5, NBYTES=32); instance B uses
// PAT_W=8, NBYTES=4. Expected values are hand-computed constants.
module tb_pattern_scan_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [4:0] pattern_a;
    logic [7:0] pattern_b;
    logic [7:0] base_a, base_b;
`ifdef PATCNT_MASK_EN
    logic [4:0] mask_a;
    logic [7:0] mask_b;
`endif
    logic       busy_a, done_a, busy_b, done_b;
    logic [8:0] cin_a, cby_a, cst_a;
    logic [5:0] cin_b, cby_b, cst_b;

    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    logic [7:0] addr_log [0:255];
    int         rd_count;
    logic       log_clr;

    int n_checks = 0;
    int n_errors = 0;

    pattern_scan_engine_if #(.ADDR_W(8)) bus_a ();
    pattern_scan_engine_if #(.ADDR_W(8)) bus_b ();

    pattern_scan_engine dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start_a),
        .pattern    (pattern_a),
`ifdef PATCNT_MASK_EN
        .pat_mask   (mask_a),
`endif
        .base_addr  (base_a),
        .mem        (bus_a),
        .busy       (busy_a),
        .done       (done_a),
        .cnt_inbyte (cin_a),
        .cnt_bytes  (cby_a),
        .cnt_stream (cst_a)
    );

    pattern_scan_engine #(.PAT_W(8), .NBYTES(4)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start_b),
        .pattern    (pattern_b),
`ifdef PATCNT_MASK_EN
        .pat_mask   (mask_b),
`endif
        .base_addr  (base_b),
        .mem        (bus_b),
        .busy       (busy_b),
        .done       (done_b),
        .cnt_inbyte (cin_b),
        .cnt_bytes  (cby_b),
        .cnt_stream (cst_b)
    );

    always #5 clk = ~clk;

    // One-cycle-latency memories plus a log of the addresses DUT A reads.
    always @(posedge clk) begin
        if (bus_a.mem_rd) bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
        if (bus_b.mem_rd) bus_b.mem_rdata <= mem_b[bus_b.mem_addr];
        if (log_clr) begin
            rd_count <= 0;
        end else if (bus_a.mem_rd) begin
            addr_log[rd_count[7:0]] <= bus_a.mem_addr;
            rd_count <= rd_count + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic fill_a(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem_a[i] = v;
    endtask

    // Start a run on DUT A, wait for done (bounded) and check the results.
    // mid_start pulses a second start with a different pattern during the run.
    task automatic run_a(input string tag, input logic [4:0] pat, input logic [4:0] msk,
                         input logic [7:0] base, input int exp_in, input int exp_by,
                         input int exp_st, input bit mid_start);
        int e;
        @(negedge clk);
        pattern_a = pat;
        base_a    = base;
`ifdef PATCNT_MASK_EN
        mask_a    = msk;
`endif
        start_a   = 1'b1;
        log_clr   = 1'b1;
        @(negedge clk);
        start_a   = 1'b0;
        log_clr   = 1'b0;
        check_val({tag, "_busy_up"}, 32'(busy_a), 32'd1);
        check_val({tag, "_rd_first"}, 32'(bus_a.mem_rd), 32'd1);
        e = 1;
        while (!done_a && e < 200) begin
            @(negedge clk);
            e++;
            if (mid_start && e == 6) begin
                start_a   = 1'b1;
                pattern_a = ~pat;
            end else begin
                start_a   = 1'b0;
            end
        end
        start_a = 1'b0;
        check_val({tag, "_latency"}, done_a ? 32'(e) : 32'd0, 32'd34);
        check_val({tag, "_busy_down"}, 32'(busy_a), 32'd0);
        check_val({tag, "_reads"}, 32'(rd_count), 32'd32);
        check_val({tag, "_inbyte"}, 32'(cin_a), 32'(exp_in));
        check_val({tag, "_bytes"}, 32'(cby_a), 32'(exp_by));
        check_val({tag, "_stream"}, 32'(cst_a), 32'(exp_st));
        if (msk == 5'd0) $display("note: %s run with empty mask", tag);
    endtask

    initial begin
        int e;
        reset     = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        pattern_a = 5'd0;
        pattern_b = 8'd0;
        base_a    = 8'd0;
        base_b    = 8'd0;
        log_clr   = 1'b1;
`ifdef PATCNT_MASK_EN
        mask_a    = 5'h1F;
        mask_b    = 8'hFF;
`endif
        for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
        fill_a(8'hFF);
        #1;
        check_val("rst_busy", 32'(busy_a), 32'd0);
        check_val("rst_done", 32'(done_a), 32'd0);
        check_val("rst_rd", 32'(bus_a.mem_rd), 32'd0);
        check_val("rst_addr", 32'(bus_a.mem_addr), 32'd0);
        check_val("rst_stream", 32'(cst_a), 32'd0);
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        log_clr = 1'b0;

        // All ones, pattern 11111: 4 in-byte hits per byte, 252 stream windows.
        run_a("ones", 5'b11111, 5'h1F, 8'h00, 128, 32, 252, 1'b0);

        // Only a byte-crossing match: 0x03 0xE0 gives one stream hit.
        fill_a(8'h00);
        mem_a[0] = 8'h03;
        mem_a[1] = 8'hE0;
        run_a("cross", 5'b11111, 5'h1F, 8'h00, 0, 0, 1, 1'b0);

        // All zeros from base 0xF0: address wraps at the 17th read.
        fill_a(8'h00);
        run_a("wrap", 5'b00000, 5'h1F, 8'hF0, 128, 32, 252, 1'b0);
        check_val("wrap_addr0", 32'(addr_log[0]), 32'hF0);
        check_val("wrap_addr15", 32'(addr_log[15]), 32'hFF);
        check_val("wrap_addr16", 32'(addr_log[16]), 32'h00);

        // Reset 10 cycles into a run clears everything at once.
        fill_a(8'hFF);
        @(negedge clk);
        pattern_a = 5'b11111;
        base_a    = 8'h00;
        start_a   = 1'b1;
        @(negedge clk);
        start_a   = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(busy_a), 32'd0);
        check_val("mid_rst_done", 32'(done_a), 32'd0);
        check_val("mid_rst_rd", 32'(bus_a.mem_rd), 32'd0);
        check_val("mid_rst_addr", 32'(bus_a.mem_addr), 32'd0);
        check_val("mid_rst_inbyte", 32'(cin_a), 32'd0);
        check_val("mid_rst_stream", 32'(cst_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fresh run after reset; a start issued mid-run must be ignored.
        run_a("after_rst", 5'b11111, 5'h1F, 8'h00, 128, 32, 252, 1'b1);

        // Masked compare: only the outer pattern bits matter when enabled.
`ifdef PATCNT_MASK_EN
        run_a("mask", 5'b10001, 5'b10001, 8'h00, 128, 32, 252, 1'b0);
`else
        run_a("mask", 5'b10001, 5'b10001, 8'h00, 0, 0, 0, 1'b0);
`endif

        // PAT_W=8, NBYTES=4: A5 A5 00 A5 with pattern A5.
        mem_b[0] = 8'hA5;
        mem_b[1] = 8'hA5;
        mem_b[2] = 8'h00;
        mem_b[3] = 8'hA5;
        @(negedge clk);
        pattern_b = 8'hA5;
        start_b   = 1'b1;
        @(negedge clk);
        start_b   = 1'b0;
        e = 1;
        while (!done_b && e < 100) begin
            @(negedge clk);
            e++;
        end
        check_val("w8_latency", done_b ? 32'(e) : 32'd0, 32'd6);
        check_val("w8_inbyte", 32'(cin_b), 32'd3);
        check_val("w8_bytes", 32'(cby_b), 32'd3);
        check_val("w8_stream", 32'(cst_b), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
